// File: rtl/syn_fft_pkg.sv
// rtl/syn_fft_pkg.sv - shared types and constants for the FFT power reader.
// Address/entry typedefs describe the default 128-point, 32-bit power geometry.
package syn_fft_pkg;

  localparam int PIPE_DEPTH      = 3;
  localparam int DEF_NUM_SAMPLES = 128;
  localparam int DEF_PWR_W       = 32;

  typedef logic [$clog2(DEF_NUM_SAMPLES)-1:0] fft_addr_t;

  typedef struct packed {
    logic [DEF_PWR_W-1:0]               pwr;
    logic [$clog2(DEF_NUM_SAMPLES)-2:0] bin;
    logic                               last;
  } pwr_entry_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

endpackage

// File: rtl/syn_fft_pwr_rdr_if.sv
// rtl/syn_fft_pwr_rdr_if.sv - FFT RAM read port plus power-bin stream.
// master = power reader, slave = RAM and downstream sink.
interface syn_fft_pwr_rdr_if #(
  parameter int NUM_SAMPLES = 128,
  parameter int DATA_W      = 32,
  parameter int PWR_W       = 32
);
  localparam int AW = $clog2(NUM_SAMPLES);

  logic                     fft_rd_en;
  logic [AW-1:0]            fft_rd_addr;
  logic signed [DATA_W-1:0] fft_rd_re;
  logic signed [DATA_W-1:0] fft_rd_im;
  logic                     pwr_valid;
  logic                     pwr_ready;
  logic [PWR_W-1:0]         pwr_data;
  logic [AW-2:0]            pwr_bin;
  logic                     pwr_last;

  modport master (
    output fft_rd_en, fft_rd_addr, pwr_valid, pwr_data, pwr_bin, pwr_last,
    input  fft_rd_re, fft_rd_im, pwr_ready
  );

  modport slave (
    input  fft_rd_en, fft_rd_addr, pwr_valid, pwr_data, pwr_bin, pwr_last,
    output fft_rd_re, fft_rd_im, pwr_ready
  );
endinterface

// File: rtl/syn_fft_pwr_fifo.sv
// rtl/syn_fft_pwr_fifo.sv - synchronous FIFO with registered head output.
// A write into an empty FIFO is forwarded straight into the output register.
module syn_fft_pwr_fifo #(
  parameter  int WIDTH = 39,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    mem_count;
  logic             load, mem_empty, take, push;

  always_comb begin
    load      = !out_valid || rd_ready;
    mem_empty = (mem_count == '0);
    take      = load && !mem_empty;
    push      = wr_en && !(load && mem_empty);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (take) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (load) begin
        out_valid <= wr_en;
        if (wr_en) out_data <= wr_data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      mem_count <= mem_count + CW'(push) - CW'(take);
    end
  end

  assign count = mem_count + CW'(out_valid);

endmodule

// File: rtl/syn_fft_pwr_rdr.sv
// rtl/syn_fft_pwr_rdr.sv - reads FFT bins 0..N/2-1 and streams re^2+im^2 power.
// Optional SYN_FFT_PWR_SAT_EN saturates the narrowed power instead of truncating.
module syn_fft_pwr_rdr
  import syn_fft_pkg::*;
#(
  parameter int NUM_SAMPLES = 128,
  parameter int DATA_W      = 32,
  parameter int PWR_W       = 32,
  parameter int PWR_SHIFT   = 31,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fft_done,
  syn_fft_pwr_rdr_if.master     bus,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int AW   = $clog2(NUM_SAMPLES);
  localparam int BW   = AW - 1;
  localparam int HALF = NUM_SAMPLES / 2;
  localparam int PW   = 2 * DATA_W;
  localparam int SW   = PW + 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PWR_W-1:0] pwr;
    logic [BW-1:0]    bin;
    logic             last;
  } entry_t;

  state_t                   state;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic [PIPE_DEPTH-1:0]    vld;
  logic [BW-1:0]            bin_ret, bin_reg, bin_prod;
  logic                     last_ret, last_reg, last_prod;
  logic signed [DATA_W-1:0] re_q, im_q;
  logic signed [PW-1:0]     prod_re, prod_im;
  logic [SW-1:0]            sum;
  logic [PWR_W-1:0]         pwr_n;
  logic [CW-1:0]            fifo_count;
  logic [2:0]               in_flight;
  logic                     credit, last_pop;
  entry_t                   wr_entry, out_entry;

  // Reads still in the RAM/multiply pipeline reserve FIFO space before issue.
  always_comb begin
    in_flight = 3'(rd_en) + 3'(vld[0]) + 3'(vld[1]) + 3'(vld[2]);
    credit    = (int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH;
    last_pop  = bus.pwr_valid && bus.pwr_ready && bus.pwr_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (fft_done) begin
          state   <= READ;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
        end
        READ: if (rd_en && rd_addr == AW'(HALF - 1)) begin
          state <= DRAIN;
          rd_en <= 1'b0;
        end else if (credit) begin
          rd_en   <= 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end else begin
          rd_en <= 1'b0;
        end
        DRAIN: if (last_pop) begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      bin_ret   <= '0;
      bin_reg   <= '0;
      bin_prod  <= '0;
      last_ret  <= 1'b0;
      last_reg  <= 1'b0;
      last_prod <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      prod_re   <= '0;
      prod_im   <= '0;
    end else begin
      vld       <= {vld[PIPE_DEPTH-2:0], rd_en};
      bin_ret   <= rd_addr[BW-1:0];
      last_ret  <= (rd_addr == AW'(HALF - 1));
      re_q      <= bus.fft_rd_re;
      im_q      <= bus.fft_rd_im;
      bin_reg   <= bin_ret;
      last_reg  <= last_ret;
      prod_re   <= re_q * re_q;
      prod_im   <= im_q * im_q;
      bin_prod  <= bin_reg;
      last_prod <= last_reg;
    end
  end

`ifdef SYN_FFT_PWR_SAT_EN
  logic [SW-1:0] shifted;
  always_comb begin
    sum     = {1'b0, prod_re} + {1'b0, prod_im};
    shifted = sum >> PWR_SHIFT;
    pwr_n   = (|(shifted >> PWR_W)) ? '1 : shifted[PWR_W-1:0];
  end
`else
  always_comb begin
    sum   = {1'b0, prod_re} + {1'b0, prod_im};
    pwr_n = PWR_W'(sum >> PWR_SHIFT);
  end
`endif

  always_comb begin
    wr_entry.pwr  = pwr_n;
    wr_entry.bin  = bin_prod;
    wr_entry.last = last_prod;
  end

  syn_fft_pwr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (vld[PIPE_DEPTH-1]),
    .wr_data   (wr_entry),
    .rd_ready  (bus.pwr_ready),
    .out_valid (bus.pwr_valid),
    .out_data  (out_entry),
    .count     (fifo_count)
  );

  assign bus.fft_rd_en   = rd_en;
  assign bus.fft_rd_addr = rd_addr;
  assign bus.pwr_data    = out_entry.pwr;
  assign bus.pwr_bin     = out_entry.bin;
  assign bus.pwr_last    = out_entry.last;

endmodule

// File: tb/tb_syn_fft_pwr_rdr.sv
// tb/tb_syn_fft_pwr_rdr.sv - scoreboard bench for syn_fft_pwr_rdr (8-point and 128-point builds).
// Honours SYN_FFT_PWR_SAT_EN when computing expected power.
module tb_syn_fft_pwr_rdr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  logic ready  = 1'b0;
  bit   sel    = 1'b0;
  int   mode   = 0;
  int   cyc    = 0;
  int   nassert = 0;
  int   nfail   = 0;
  logic busy_a, busy_b, fd_a, fd_b;

  always @(posedge clk) cyc <= cyc + 1;

  syn_fft_pwr_rdr_if #(.NUM_SAMPLES(8),   .DATA_W(32), .PWR_W(32)) if_a ();
  syn_fft_pwr_rdr_if #(.NUM_SAMPLES(128), .DATA_W(32), .PWR_W(32)) if_b ();

  assign if_a.pwr_ready = ready & ~sel;
  assign if_b.pwr_ready = ready & sel;

  syn_fft_pwr_rdr #(.NUM_SAMPLES(8), .DATA_W(32), .PWR_W(32), .PWR_SHIFT(0), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .fft_done(done_a), .bus(if_a), .busy(busy_a), .frame_done(fd_a));
  syn_fft_pwr_rdr #(.NUM_SAMPLES(128), .DATA_W(32), .PWR_W(32), .PWR_SHIFT(31), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .fft_done(done_b), .bus(if_b), .busy(busy_b), .frame_done(fd_b));

  typedef struct {
    logic [31:0] pwr;
    int          bin;
    bit          last;
  } exp_t;
  exp_t sb[$];

  function automatic logic signed [31:0] pat_re(int k);
    case (mode)
      0: return 32'(k);
      1: return 32'sd3;
      2: return 32'(k << 20);
      default: return 32'sh80000000;
    endcase
  endfunction

  function automatic logic signed [31:0] pat_im(int k);
    case (mode)
      0: return 32'sd0;
      1: return -32'sd4;
      2: return -32'(k << 19);
      default: return 32'sh80000000;
    endcase
  endfunction

  function automatic logic [31:0] model(logic signed [31:0] re, logic signed [31:0] im, int sh);
    logic signed [63:0] a, b;
    logic [64:0] s;
    a = 64'(re) * 64'(re);
    b = 64'(im) * 64'(im);
    s = {1'b0, a} + {1'b0, b};
    s = s >> sh;
`ifdef SYN_FFT_PWR_SAT_EN
    if (s[64:32] != '0) return 32'hFFFFFFFF;
`endif
    return s[31:0];
  endfunction

  // FFT RAM models: data one cycle after the strobe; expected entry queued at issue.
  always @(posedge clk) begin
    if (if_a.fft_rd_en) begin
      if_a.fft_rd_re <= pat_re(int'(if_a.fft_rd_addr));
      if_a.fft_rd_im <= pat_im(int'(if_a.fft_rd_addr));
      sb.push_back('{model(pat_re(int'(if_a.fft_rd_addr)), pat_im(int'(if_a.fft_rd_addr)), 0),
                     int'(if_a.fft_rd_addr), if_a.fft_rd_addr == 3'd3});
    end
    if (if_b.fft_rd_en) begin
      if_b.fft_rd_re <= pat_re(int'(if_b.fft_rd_addr));
      if_b.fft_rd_im <= pat_im(int'(if_b.fft_rd_addr));
      sb.push_back('{model(pat_re(int'(if_b.fft_rd_addr)), pat_im(int'(if_b.fft_rd_addr)), 31),
                     int'(if_b.fft_rd_addr), if_b.fft_rd_addr == 7'd63});
    end
  end

  logic        s_rd_en, s_valid, s_last, s_busy, s_fd;
  int          s_addr, s_bin;
  logic [31:0] s_data;
  always_comb begin
    s_rd_en = sel ? if_b.fft_rd_en : if_a.fft_rd_en;
    s_addr  = sel ? int'(if_b.fft_rd_addr) : int'(if_a.fft_rd_addr);
    s_valid = sel ? if_b.pwr_valid : if_a.pwr_valid;
    s_data  = sel ? if_b.pwr_data : if_a.pwr_data;
    s_bin   = sel ? int'(if_b.pwr_bin) : int'(if_a.pwr_bin);
    s_last  = sel ? if_b.pwr_last : if_a.pwr_last;
    s_busy  = sel ? busy_b : busy_a;
    s_fd    = sel ? fd_b : fd_a;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input bit s, input int nb, input int rmode, input bit extra_done);
    int t0, got, exp_addr, issued, max_out, fd_cnt, t_fd, t_rd0, extra_rd;
    bit stalled;
    logic [31:0] hd;
    int hb;
    bit hl;
    exp_t e;
    sel = s;
    got = 0; exp_addr = 0; issued = 0; max_out = 0; fd_cnt = 0;
    t_fd = -1; t_rd0 = -1; extra_rd = 0; stalled = 0; hd = '0; hb = 0; hl = 0;
    @(negedge clk);
    check("busy_idle", s_busy, 0);
    if (s) done_b = 1'b1; else done_a = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 3000 && fd_cnt == 0; c++) begin
      @(negedge clk);
      done_a = 1'b0;
      done_b = 1'b0;
      if (c == 0) check("busy_rise", s_busy, 1);
      if (extra_done && c == 6) begin
        if (s) done_b = 1'b1; else done_a = 1'b1;
      end
      ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
      if (s_rd_en) begin
        if (t_rd0 < 0) t_rd0 = cyc;
        check("rd_addr", s_addr, exp_addr);
        exp_addr++;
        issued++;
      end
      if (s_valid) begin
        if (stalled) begin
          check("hold_data", s_data, hd);
          check("hold_bin", s_bin, hb);
          check("hold_last", s_last, hl);
        end
        if (ready) begin
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pwr_data", s_data, e.pwr);
            check("pwr_bin", s_bin, e.bin);
            check("pwr_last", s_last, e.last);
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = s_data; hb = s_bin; hl = s_last;
        end
      end else begin
        stalled = 0;
      end
      if (issued - got > max_out) max_out = issued - got;
      if (s_fd) begin
        fd_cnt++;
        t_fd = cyc;
      end
    end
    check("frame_done_seen", fd_cnt, 1);
    check("bins_out", got, nb);
    check("first_rd_cycle", t_rd0, t0 + 1);
    if (rmode == 0) check("frame_done_cycle", t_fd, t0 + 1 + nb + 4);
    check("outstanding_le_depth", max_out <= 8, 1);
    check("busy_fall", s_busy, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_fd) fd_cnt++;
      if (s_rd_en) extra_rd++;
    end
    check("single_frame_done", fd_cnt, 1);
    check("no_reads_after", extra_rd, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", if_a.fft_rd_en, 0);
    check("rst_rd_addr", if_b.fft_rd_addr, 0);
    check("rst_valid", if_b.pwr_valid, 0);
    check("rst_data", if_a.pwr_data, 0);
    check("rst_busy", busy_b, 0);
    check("rst_frame_done", fd_a, 0);
    rst_n = 1'b1;

    mode = 0; run_frame(1'b0, 4, 0, 1'b0);
    mode = 1; run_frame(1'b0, 4, 0, 1'b0);
    mode = 2; run_frame(1'b1, 64, 1, 1'b0);
    mode = 3; run_frame(1'b1, 64, 0, 1'b0);
    mode = 2; run_frame(1'b1, 64, 0, 1'b1);

    mode = 1;
    sel  = 1'b1;
    ready = 1'b1;
    @(negedge clk); done_b = 1'b1;
    @(negedge clk); done_b = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", if_b.fft_rd_en, 0);
    check("mid_rst_rd_addr", if_b.fft_rd_addr, 0);
    check("mid_rst_valid", if_b.pwr_valid, 0);
    check("mid_rst_data", if_b.pwr_data, 0);
    check("mid_rst_bin", if_b.pwr_bin, 0);
    check("mid_rst_last", if_b.pwr_last, 0);
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_frame_done", fd_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    run_frame(1'b1, 64, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
